// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
// Optional perf counters are enabled with IFU_PERF_COUNTERS_EN.
package instruction_fetch_unit_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; used for pending PCs and fetched instructions.
// Synchronous active-high reset, flush has priority over push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC owner, imem request issue, response queueing, redirect flush.
// Define IFU_PERF_COUNTERS_EN to add perf_fetched/perf_dropped outputs.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
`ifdef IFU_PERF_COUNTERS_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
`endif
  output logic [31:0] instr_pc
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic          accept, resp_ok, resp_drop, resp_keep, pop;
  logic [31:0]   live_total;
  logic [31:0]   pend_pc;
  logic [OW-1:0] pq_count;
  logic [FW-1:0] iq_count;
  logic          pq_full, pq_empty, iq_full, iq_empty;
  fetch_entry_t  iq_in, iq_head;

  // Pending-PC occupancy equals the live (non-stale) outstanding count.
  assign live_total = 32'(pq_count) + 32'(iq_count);

  assign imem_req_valid = (state_q != BOOT)
                       && (outstanding_q < OW'(MAX_OUTSTANDING))
                       && (live_total < 32'(FIFO_DEPTH))
                       && !pq_full && !iq_full;
  assign imem_req_addr  = pc_q;

  assign accept    = imem_req_valid && imem_req_ready;
  assign resp_ok   = imem_resp_valid && (outstanding_q != '0);
  assign resp_drop = resp_ok && (discard_q != '0);
  assign resp_keep = resp_ok && (discard_q == '0) && !pq_empty;

  assign instr_valid = !iq_empty;
  assign instr_data  = iq_head.instr;
  assign instr_pc    = iq_head.pc;
  assign pop         = instr_valid && instr_ready;
  assign iq_in       = {pend_pc, imem_resp_data};

  always_comb begin
    outstanding_d = outstanding_q + OW'(accept) - OW'(resp_ok);
    discard_d     = discard_q - OW'(resp_drop);
    pc_d          = pc_q;
    if (accept) pc_d = pc_q + 32'(INSTR_BYTES);
    // Anything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      discard_d = outstanding_d;
    end
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH,
      DRAIN:   state_d = (discard_d != '0) ? DRAIN : FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_q (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !redirect_valid),
    .push_data (pc_q),
    .pop       (resp_keep),
    .pop_data  (pend_pc),
    .flush     (redirect_valid),
    .full      (pq_full),
    .empty     (pq_empty),
    .count     (pq_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_keep),
    .push_data (iq_in),
    .pop       (pop),
    .pop_data  (iq_head),
    .flush     (redirect_valid),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  // A head popped in the redirect cycle counts as fetched, not flushed.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 32'(resp_drop);
    if (redirect_valid)
      perf_dropped_d = perf_dropped_d + 32'(iq_count) - 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle in-order imem model.
// Perf counter checks are included when IFU_PERF_COUNTERS_EN is defined.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int          tests = 0;
  int          fails = 0;
  logic        resp_en = 1'b0;
  logic [31:0] mem_q [$];

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
`ifdef IFU_PERF_COUNTERS_EN
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped),
`endif
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // imem: answers each accepted request one cycle later, in order.
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] acc_addr;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    #1;
    if (acc) mem_q.push_back(acc_addr);
    if (resp_en && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  task automatic do_reset(input logic r_en, input logic rdy,
                          input logic irdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_en        = r_en;
    imem_req_ready = rdy;
    instr_ready    = irdy;
    repeat (2) @(negedge clk);
    mem_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_en = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
      fails++;
    end
    tests++;
    if (instr_valid !== 1'b0) begin
      $display("FAIL rst_instr_valid: got %b want 0", instr_valid);
      fails++;
    end
`ifdef IFU_PERF_COUNTERS_EN
    tests++;
    if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0) begin
      $display("FAIL rst_perf: got %h/%h want 0/0",
               perf_fetched, perf_dropped);
      fails++;
    end
`endif
    mem_q.delete();
    reset = 1'b0;
    tests++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL boot_req_valid: got %b want 0", imem_req_valid);
      fails++;
    end
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      $display("FAIL first_req: got v=%b a=%h want v=1 a=0",
               imem_req_valid, imem_req_addr);
      fails++;
    end
  endtask

  task automatic test_sequential();
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
        $display("FAIL seq_addr[%0d]: got v=%b a=%h want v=1 a=%h",
                 i, imem_req_valid, imem_req_addr, 32'(4 * i));
        fails++;
      end
      tests++;
      if (i < 2) begin
        if (instr_valid !== 1'b0) begin
          $display("FAIL seq_early_valid[%0d]: got %b want 0",
                   i, instr_valid);
          fails++;
        end
      end else if (instr_valid !== 1'b1 ||
                   instr_pc !== 32'(4 * (i - 2)) ||
                   instr_data !== word_of(32'(4 * (i - 2)))) begin
        $display("FAIL seq_instr[%0d]: got v=%b pc=%h d=%h want pc=%h d=%h",
                 i, instr_valid, instr_pc, instr_data,
                 32'(4 * (i - 2)), word_of(32'(4 * (i - 2))));
        fails++;
      end
    end
`ifdef IFU_PERF_COUNTERS_EN
    @(negedge clk);
    tests++;
    if (perf_fetched !== 32'd6) begin
      $display("FAIL seq_perf_fetched: got %0d want 6", perf_fetched);
      fails++;
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] acc_a [8];
    logic [31:0] pcs [5];
    logic [31:0] first_acc;
    int          n_acc;
    int          npop;
    logic        got_acc;
    do_reset(1'b1, 1'b1, 1'b0);
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (n_acc < 8) acc_a[n_acc] = imem_req_addr;
        n_acc++;
      end
    end
    tests++;
    if (n_acc != 4) begin
      $display("FAIL bp_accepts: got %0d want 4", n_acc);
      fails++;
    end
    for (int k = 0; k < 4 && k < n_acc; k++) begin
      tests++;
      if (acc_a[k] !== 32'(4 * k)) begin
        $display("FAIL bp_addr[%0d]: got %h want %h",
                 k, acc_a[k], 32'(4 * k));
        fails++;
      end
    end
    tests++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 ||
        instr_pc !== 32'h0) begin
      $display("FAIL bp_full: got rv=%b iv=%b pc=%h want rv=0 iv=1 pc=0",
               imem_req_valid, instr_valid, instr_pc);
      fails++;
    end
    instr_ready = 1'b1;
    npop = 0;
    got_acc = 1'b0;
    first_acc = '0;
    for (int c = 0; c < 20 && npop < 5; c++) begin
      if (instr_valid) begin
        pcs[npop] = instr_pc;
        npop++;
      end
      if (imem_req_valid && imem_req_ready && !got_acc) begin
        first_acc = imem_req_addr;
        got_acc = 1'b1;
      end
      @(negedge clk);
    end
    tests++;
    if (npop != 5) begin
      $display("FAIL bp_drain_count: got %0d want 5", npop);
      fails++;
    end
    for (int k = 0; k < npop; k++) begin
      tests++;
      if (pcs[k] !== 32'(4 * k)) begin
        $display("FAIL bp_drain_pc[%0d]: got %h want %h",
                 k, pcs[k], 32'(4 * k));
        fails++;
      end
    end
    tests++;
    if (!got_acc || first_acc !== 32'h10) begin
      $display("FAIL bp_resume: got seen=%b a=%h want a=00000010",
               got_acc, first_acc);
      fails++;
    end
  endtask

  task automatic test_redirect_drop();
    logic seen;
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL rd_max_out: got %b want 0", imem_req_valid);
      fails++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    resp_en        = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      if (instr_valid) begin
        seen = 1'b1;
        tests++;
        if (instr_pc !== 32'h100 || instr_data !== word_of(32'h100)) begin
          $display("FAIL rd_first: got pc=%h d=%h want pc=100 d=%h",
                   instr_pc, instr_data, word_of(32'h100));
          fails++;
        end
`ifdef IFU_PERF_COUNTERS_EN
        tests++;
        if (perf_dropped !== 32'd2) begin
          $display("FAIL rd_perf_dropped: got %0d want 2", perf_dropped);
          fails++;
        end
`endif
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL rd_timeout: got no instr want pc=100");
    end
  endtask

  task automatic test_stall_redirect();
    logic seen;
    do_reset(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        $display("FAIL stall_hold[%0d]: got v=%b a=%h want v=1 a=0",
                 c, imem_req_valid, imem_req_addr);
        fails++;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      $display("FAIL stall_redir: got v=%b a=%h want v=1 a=200",
               imem_req_valid, imem_req_addr);
      fails++;
    end
    imem_req_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        tests++;
        if (instr_pc !== 32'h200) begin
          $display("FAIL stall_instr: got %h want 200", instr_pc);
          fails++;
        end
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout: got no instr want pc=200");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] acc_a [3];
    logic [31:0] pcs [3];
    logic [31:0] exp_a [3];
    int          n_acc;
    int          npop;
    exp_a[0] = 32'hFFFF_FFF8;
    exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000;
    do_reset(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_acc = 0;
    npop  = 0;
    for (int c = 0; c < 20 && npop < 3; c++) begin
      if (imem_req_valid && imem_req_ready && n_acc < 3) begin
        acc_a[n_acc] = imem_req_addr;
        n_acc++;
      end
      if (instr_valid && instr_ready) begin
        pcs[npop] = instr_pc;
        npop++;
      end
      @(negedge clk);
    end
    tests++;
    if (n_acc != 3 || npop != 3) begin
      $display("FAIL wrap_count: got acc=%0d pop=%0d want 3/3",
               n_acc, npop);
      fails++;
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ((k < n_acc && acc_a[k] !== exp_a[k]) ||
          (k < npop && pcs[k] !== exp_a[k])) begin
        $display("FAIL wrap_addr[%0d]: got a=%h pc=%h want %h",
                 k, acc_a[k], pcs[k], exp_a[k]);
        fails++;
      end
    end
  endtask

  task automatic test_reset_in_drain();
    logic [31:0] pcs [2];
    logic [31:0] dat [2];
    int          npop;
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    reset          = 1'b1;
    resp_en        = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      $display("FAIL drain_rst: got rv=%b iv=%b want 0/0",
               imem_req_valid, instr_valid);
      fails++;
    end
`ifdef IFU_PERF_COUNTERS_EN
    tests++;
    if (perf_dropped !== 32'd0) begin
      $display("FAIL drain_rst_perf: got %0d want 0", perf_dropped);
      fails++;
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      $display("FAIL drain_restart: got v=%b a=%h want v=1 a=0",
               imem_req_valid, imem_req_addr);
      fails++;
    end
    npop = 0;
    for (int c = 0; c < 12 && npop < 2; c++) begin
      if (instr_valid && instr_ready) begin
        pcs[npop] = instr_pc;
        dat[npop] = instr_data;
        npop++;
      end
      @(negedge clk);
    end
    tests++;
    if (npop != 2) begin
      $display("FAIL drain_count: got %0d want 2", npop);
      fails++;
    end
    for (int k = 0; k < npop; k++) begin
      tests++;
      if (pcs[k] !== 32'(4 * k) || dat[k] !== word_of(32'(4 * k))) begin
        $display("FAIL drain_instr[%0d]: got pc=%h d=%h want pc=%h d=%h",
                 k, pcs[k], dat[k], 32'(4 * k), word_of(32'(4 * k)));
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_stall_redirect();
    test_wrap();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
